// File: rtl/player_input.sv
// Button front end for the room FSM: synchronizes and debounces four buttons, emits one-cycle
// move pulses, tracks the sword flag. Define PLAYER_INPUT_MOVE_CNT_EN to build the move counter.
module player_input #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_n,
    input  logic       btn_s,
    input  logic       btn_e,
    input  logic       btn_w,
    input  logic       sw,
    input  logic       win,
    input  logic       die,
    output logic       n,
    output logic       s,
    output logic       e,
    output logic       w,
    output logic       k,
    output logic [7:0] move_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        WAIT_REL,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit order everywhere is {n, s, e, w}, so bit 3 carries the highest priority.
    logic [3:0]       btn;
    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       db;
    logic [CNT_W-1:0] cnt [4];
    logic [3:0]       pulse_q;
    logic [3:0]       next_pulse;
    state_t           state;
    state_t           next_state;

    assign btn = {btn_n, btn_s, btn_e, btn_w};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pulse_q <= '0;
        end else begin
            state   <= next_state;
            pulse_q <= next_pulse;
        end
    end

    always_comb begin
        next_state = state;
        next_pulse = '0;
        case (state)
            IDLE: begin
                if (|db) begin
                    next_state = PULSE;
                    if (db[3])      next_pulse = 4'b1000;
                    else if (db[2]) next_pulse = 4'b0100;
                    else if (db[1]) next_pulse = 4'b0010;
                    else            next_pulse = 4'b0001;
                end
            end
            PULSE:    next_state = WAIT_REL;
            WAIT_REL: if (db == 4'b0000) next_state = IDLE;
            DONE:     next_state = DONE;
            default:  next_state = IDLE;
        endcase
        // End of game overrides everything, including a pulse about to be issued.
        if (win || die) begin
            next_state = DONE;
            next_pulse = '0;
        end
    end

    assign n = pulse_q[3];
    assign s = pulse_q[2];
    assign e = pulse_q[1];
    assign w = pulse_q[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            k <= 1'b0;
        end else if (sw) begin
            k <= 1'b1;
        end
    end

`ifdef PLAYER_INPUT_MOVE_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            move_cnt <= '0;
        end else if (state == PULSE && move_cnt != 8'hFF) begin
            move_cnt <= move_cnt + 8'd1;
        end
    end
`else
    assign move_cnt = 8'd0;
`endif

endmodule
